// File: rtl/nexusv_lsu.sv
// NexusV load/store unit: steers RV32I loads and stores to a local RAM or an
// APB-style bus, with lane placement, load extension and error reporting.
module nexusv_lsu #(
  parameter logic [31:0] RAM_BASE       = 32'h0000_2000,
  parameter int unsigned RAM_AW         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata,
  output logic              bus_valid,
  output logic              bus_write,
  output logic [31:0]       bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_strb,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_DECODE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
  localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAM_ACC  = 3'd1,
    RAM_DATA = 3'd2,
    BUS_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_write;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_ram_en;
  logic        r_bus_valid;
  logic [31:0] r_rsp_rdata;
  logic [31:0] w_rsp_rdata_nxt;
  logic [1:0]  r_rsp_err;
  logic [1:0]  w_rsp_err_nxt;
  logic        w_accept;

  logic        w_ram_hit;
  logic        w_bus_hit;
  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_strb;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request classification, evaluated on the live request at accept time
  always_comb begin
    w_ram_hit  = (req_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
    w_bus_hit  = req_addr[31];
    w_illegal  = req_write ? (req_funct3 >= 3'd3)
                           : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Byte strobes and lane replication from the captured request
  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_strb       = 4'b0001 << r_addr[1:0];
        w_lane_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb       = 4'b0011 << {r_addr[1], 1'b0};
        w_lane_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_strb       = 4'b1111;
        w_lane_wdata = r_wdata;
      end
    endcase
  end

  // Lane selection and sign/zero extension of returned load data
  always_comb begin
    w_src  = (r_state == BUS_WAIT) ? bus_rdata : ram_rdata;
    w_byte = w_src[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? w_src[31:16] : w_src[15:0];
    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = w_src;
    endcase
    if (r_write) begin
      w_load = '0;
    end
  end

  // Next-state and response selection
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_accept        = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = '0;
          if (w_illegal || !(w_ram_hit || w_bus_hit)) begin
            w_state_nxt     = RESP;
            w_rsp_rdata_nxt = '0;
            w_rsp_err_nxt   = ERR_DECODE;
          end else if (w_misalign) begin
            w_state_nxt     = RESP;
            w_rsp_rdata_nxt = '0;
            w_rsp_err_nxt   = ERR_MISALIGN;
          end else if (w_ram_hit) begin
            w_state_nxt = RAM_ACC;
          end else begin
            w_state_nxt = BUS_WAIT;
          end
        end
      end
      RAM_ACC: begin
        w_state_nxt = RAM_DATA;
      end
      RAM_DATA: begin
        w_state_nxt     = RESP;
        w_rsp_rdata_nxt = w_load;
        w_rsp_err_nxt   = ERR_OK;
      end
      BUS_WAIT: begin
        if (bus_ready) begin
          w_state_nxt     = RESP;
          w_rsp_rdata_nxt = w_load;
          w_rsp_err_nxt   = ERR_OK;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt     = RESP;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = ERR_TIMEOUT;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with strobes registered as decodes of the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_ram_en    <= 1'b0;
      r_bus_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      r_ram_en    <= (w_state_nxt == RAM_ACC);
      r_bus_valid <= (w_state_nxt == BUS_WAIT);
    end
  end

  // Captured request, wait counter and response data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_write     <= 1'b0;
      r_cnt       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
        r_write  <= req_write;
      end
      r_cnt       <= w_cnt_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_en & r_write;
  assign ram_addr  = {r_addr[RAM_AW-1:2], 2'b00};
  assign ram_wdata = w_lane_wdata;
  assign ram_be    = r_ram_en ? w_strb : 4'b0000;

  assign bus_valid = r_bus_valid;
  assign bus_write = r_bus_valid & r_write;
  assign bus_addr  = r_addr;
  assign bus_wdata = w_lane_wdata;
  assign bus_strb  = r_bus_valid ? w_strb : 4'b0000;

endmodule

// File: tb/tb_nexusv_lsu.sv
// Scoreboard bench for nexusv_lsu: directed requests push expected responses,
// a negedge monitor pops and compares them and tracks RAM/bus activity.
module tb_nexusv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;

  always #5 clk = ~clk;

  nexusv_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // RAM model: synchronous read, byte-enable write
  logic [31:0] mem [0:1023];
  logic [31:0] ram_q = '0;
  logic [31:0] mem_w;
  assign ram_rdata = ram_q;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem_w = mem[ram_addr[11:2]];
        for (int i = 0; i < 4; i++)
          if (ram_be[i]) mem_w[8*i +: 8] = ram_wdata[8*i +: 8];
        mem[ram_addr[11:2]] <= mem_w;
      end else begin
        ram_q <= mem[ram_addr[11:2]];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  int ram_cycles = 0, bus_cycles = 0, last_ram_cyc = -1, rsp_pulses = 0;
  int overlap = 0, unstable = 0, bus_k = 0, bus_lat = 0;
  logic [3:0]  last_be = '0, lb_strb = '0;
  logic [31:0] last_ram_wdata = '0, lb_wdata = '0, lb_addr = '0;
  logic        lb_write = 1'b0, bv_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: bus responder, activity tracking and response scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (ram_en) begin
      ram_cycles++;
      last_ram_cyc = cyc;
      if (ram_we) begin
        last_be = ram_be;
        last_ram_wdata = ram_wdata;
      end
    end
    if (ram_en && bus_valid) overlap++;
    if (bus_valid) begin
      bus_cycles++;
      if (!bv_prev) begin
        lb_strb = bus_strb; lb_wdata = bus_wdata; lb_addr = bus_addr; lb_write = bus_write;
      end else if (bus_strb != lb_strb || bus_wdata != lb_wdata ||
                   bus_addr != lb_addr || bus_write != lb_write) begin
        unstable++;
      end
      bus_k++;
      bus_ready = (bus_k == bus_lat);
    end else begin
      bus_k = 0;
      bus_ready = 1'b0;
    end
    bv_prev = bus_valid;
    if (rsp_valid) begin
      rsp_pulses++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_ready(input string name);
    int t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic txn(input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3,
                     input logic [31:0] exp_rd, input logic [1:0] exp_err,
                     input int lat, input int exp_ram, input int exp_bus);
    int acc, r0, b0;
    exp_t e;
    wait_ready(name);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    acc = cyc;
    e.rdata = exp_rd; e.err = exp_err; e.cyc = acc + lat;
    sb_q.push_back(e);
    r0 = ram_cycles; b0 = bus_cycles;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain(name);
    chk({name, "_ram_cycles"}, 32'(ram_cycles - r0), 32'(exp_ram));
    chk({name, "_bus_cycles"}, 32'(bus_cycles - b0), 32'(exp_bus));
    if (exp_ram == 1) chk({name, "_ram_en_cycle"}, 32'(last_ram_cyc), 32'(acc + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, p0, r0;
    exp_t e;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h80FF_1234;
    mem[1] = 32'h1122_3344;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_ctl", 32'({rsp_valid, rsp_err, ram_en, ram_we, ram_be, bus_valid, bus_write, bus_strb}), 32'd0);
    chk("rst_data", rsp_rdata | ram_wdata | bus_addr | bus_wdata | 32'(ram_addr), 32'd0);

    // RAM loads and stores
    txn("lb_2003",  1'b0, 32'h0000_2003, 32'h0, 3'd0, 32'hFFFF_FF80, 2'b00, 3, 1, 0);
    txn("lbu_2003", 1'b0, 32'h0000_2003, 32'h0, 3'd4, 32'h0000_0080, 2'b00, 3, 1, 0);
    txn("lh_2002",  1'b0, 32'h0000_2002, 32'h0, 3'd1, 32'hFFFF_80FF, 2'b00, 3, 1, 0);
    txn("lhu_2000", 1'b0, 32'h0000_2000, 32'h0, 3'd5, 32'h0000_1234, 2'b00, 3, 1, 0);
    txn("lw_2000",  1'b0, 32'h0000_2000, 32'h0, 3'd2, 32'h80FF_1234, 2'b00, 3, 1, 0);
    txn("sb_2005",  1'b1, 32'h0000_2005, 32'h0000_005A, 3'd0, 32'h0, 2'b00, 3, 1, 0);
    chk("sb_ram_be", 32'(last_be), 32'h2);
    chk("sb_ram_wdata", last_ram_wdata, 32'h5A5A_5A5A);
    txn("lw_2004",  1'b0, 32'h0000_2004, 32'h0, 3'd2, 32'h1122_5A44, 2'b00, 3, 1, 0);
    txn("sw_2008",  1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 3'd2, 32'h0, 2'b00, 3, 1, 0);
    txn("lw_2008",  1'b0, 32'h0000_2008, 32'h0, 3'd2, 32'hDEAD_BEEF, 2'b00, 3, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rsp_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
    txn("lh_200a",  1'b0, 32'h0000_200A, 32'h0, 3'd1, 32'hFFFF_DEAD, 2'b00, 3, 1, 0);

    // Bus accesses
    bus_lat = 5;
    txn("sh_bus", 1'b1, 32'h8000_0002, 32'h0000_ABCD, 3'd1, 32'h0, 2'b00, 6, 0, 5);
    chk("sh_bus_strb", 32'(lb_strb), 32'hC);
    chk("sh_bus_wdata", lb_wdata, 32'hABCD_ABCD);
    chk("sh_bus_addr", lb_addr, 32'h8000_0002);
    chk("sh_bus_write", 32'(lb_write), 32'd1);
    bus_rdata = 32'hCAFE_F00D;
    bus_lat = 1;
    txn("lw_bus",  1'b0, 32'h8000_0010, 32'h0, 3'd2, 32'hCAFE_F00D, 2'b00, 2, 0, 1);
    bus_lat = 2;
    txn("lb_bus",  1'b0, 32'h8000_0011, 32'h0, 3'd0, 32'hFFFF_FFF0, 2'b00, 3, 0, 2);
    bus_lat = 0;
    txn("lw_tmo",  1'b0, 32'h8000_0000, 32'h0, 3'd2, 32'h0, 2'b11, 17, 0, 16);
    bus_rdata = 32'h1234_5678;
    bus_lat = 16;
    txn("lw_edge", 1'b0, 32'h8000_0004, 32'h0, 3'd2, 32'h1234_5678, 2'b00, 17, 0, 16);

    // Decode and alignment errors
    txn("lw_mis",   1'b0, 32'h0000_2002, 32'h0, 3'd2, 32'h0, 2'b01, 1, 0, 0);
    txn("lh_mis",   1'b0, 32'h0000_2001, 32'h0, 3'd1, 32'h0, 2'b01, 1, 0, 0);
    txn("lb_unmap", 1'b0, 32'h0000_1000, 32'h0, 3'd0, 32'h0, 2'b10, 1, 0, 0);
    txn("ld_f3_3",  1'b0, 32'h0000_2000, 32'h0, 3'd3, 32'h0, 2'b10, 1, 0, 0);
    txn("st_f3_4",  1'b1, 32'h0000_2000, 32'h1, 3'd4, 32'h0, 2'b10, 1, 0, 0);
    txn("lw_prio",  1'b0, 32'h0000_1002, 32'h0, 3'd2, 32'h0, 2'b10, 1, 0, 0);
    txn("sw_busmis",1'b1, 32'h8000_0001, 32'h1, 3'd2, 32'h0, 2'b01, 1, 0, 0);

    // Reset during the third bus wait cycle
    bus_lat = 0;
    wait_ready("rst_bus");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0000; req_funct3 = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_bus_valid_before", 32'(bus_valid), 32'd1);
    rst_n = 1'b0;
    p0 = rsp_pulses;
    @(posedge clk); #1;
    chk("rst_bus_valid_after", 32'(bus_valid), 32'd0);
    chk("rst_bus_ready_after", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_rsp", 32'(rsp_pulses - p0), 32'd0);
    chk("rst_bus_idle", 32'(bus_valid), 32'd0);
    chk("rst_rsp_regs", rsp_rdata | 32'(rsp_err), 32'd0);

    // Request held high across a RAM access
    wait_ready("hold");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_2000; req_funct3 = 3'd2;
    acc = cyc;
    r0 = ram_cycles;
    e.rdata = 32'h80FF_1234; e.err = 2'b00; e.cyc = acc + 3;
    sb_q.push_back(e);
    e.rdata = 32'h1122_5A44; e.err = 2'b00; e.cyc = acc + 7;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_addr = 32'h0000_2004;
    repeat (4) @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain("hold");
    chk("hold_ram_cycles", 32'(ram_cycles - r0), 32'd2);

    chk("no_ram_bus_overlap", 32'(overlap), 32'd0);
    chk("bus_stable", 32'(unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
